// File: rtl/rca_seq_pkg.sv
// Shared constants and FSM encoding for the byte-serial ripple-carry word sequencer.
package rca_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// Two-stage registered 8-bit ripple-carry adder: operands captured on one edge,
// sum/carry registered on the next, so a result is readable two cycles after drive.
module ripple_carry_adder
  import rca_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              ci,
  output logic [BYTE_W-1:0] sum,
  output logic              co
);

  logic [BYTE_W-1:0] a_q;
  logic [BYTE_W-1:0] b_q;
  logic              ci_q;

  // Bit-serial carry chain kept inside a function so the chain is one expression.
  function automatic logic [BYTE_W:0] ripple(input logic [BYTE_W-1:0] x,
                                             input logic [BYTE_W-1:0] y,
                                             input logic              c_in);
    logic [BYTE_W-1:0] s;
    logic              c;
    c = c_in;
    for (int i = 0; i < BYTE_W; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      ci_q <= 1'b0;
      sum  <= '0;
      co   <= 1'b0;
    end else begin
      a_q       <= a;
      b_q       <= b;
      ci_q      <= ci;
      {co, sum} <= ripple(a_q, b_q, ci_q);
    end
  end

endmodule

// File: rtl/rca_word_sequencer.sv
// Sequences a WORDS-byte add (LSB byte first) through one shared 8-bit adder.
// Optional subtract support is compiled in with `define RCA_SEQ_SUB_EN.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. start_ready is high only in IDLE; res_valid is held with stable
// res_sum/res_cout/res_ovf until res_ready is seen.
module rca_word_sequencer
  import rca_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [8*WORDS-1:0]    op_a,
  input  logic [8*WORDS-1:0]    op_b,
  input  logic                  cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic                  sub,
`endif
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [8*WORDS-1:0]    res_sum,
  output logic                  res_cout,
  output logic                  res_ovf,
  output logic                  busy
);

  localparam int N     = BYTE_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [N-1:0]      a_q;
  logic [N-1:0]      b_q;
  logic              cin_q;
  logic [N-1:0]      acc_q;

  logic [BYTE_W-1:0] add_a;
  logic [BYTE_W-1:0] add_b;
  logic              add_ci;
  logic [BYTE_W-1:0] add_sum;
  logic              add_co;
  logic [N-1:0]      drain_word;
  logic              ovf_nxt;

  ripple_carry_adder u_rca (
    .clk (clk),
    .rst (rst),
    .a   (add_a),
    .b   (add_b),
    .ci  (add_ci),
    .sum (add_sum),
    .co  (add_co)
  );

  always_comb begin
    state_nxt  = state;
    add_a      = a_q[idx*BYTE_W +: BYTE_W];
    add_b      = b_q[idx*BYTE_W +: BYTE_W];
    // The previous byte's carry is already registered when the next byte issues.
    add_ci     = (idx == '0) ? cin_q : add_co;
    drain_word = acc_q;
    drain_word[(WORDS-1)*BYTE_W +: BYTE_W] = add_sum;
    ovf_nxt    = (a_q[N-1] == b_q[N-1]) && (add_sum[BYTE_W-1] != a_q[N-1]);
    case (state)
      ST_IDLE:  if (start_valid && start_ready) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = (idx == LAST_IDX) ? ST_DRAIN : ST_ISSUE;
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  if (res_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      acc_q    <= '0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_ovf  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start_valid && start_ready) begin
            a_q <= op_a;
            idx <= '0;
`ifdef RCA_SEQ_SUB_EN
            // Subtraction is stored as A + ~B + 1, so the datapath never sees sub.
            b_q   <= sub ? ~op_b : op_b;
            cin_q <= sub ? 1'b1 : cin;
`else
            b_q   <= op_b;
            cin_q <= cin;
`endif
          end
        end
        ST_ISSUE: begin
          if (idx != '0) acc_q[(int'(idx) - 1)*BYTE_W +: BYTE_W] <= add_sum;
        end
        ST_WAIT: begin
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        ST_DRAIN: begin
          // Partial bytes live in acc_q; the visible result only changes here.
          res_sum  <= drain_word;
          res_cout <= add_co;
          res_ovf  <= ovf_nxt;
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (state == ST_IDLE);
  assign res_valid   = (state == ST_DONE);
  assign busy        = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_DRAIN);

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Self-checking bench for rca_word_sequencer (WORDS=4): vector table, corner
// sequences (held DONE, reset mid-operation) and random ops against a scoreboard.
module tb_rca_word_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;
  localparam int LAT   = 2 * WORDS + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
`ifdef RCA_SEQ_SUB_EN
  logic         sub;
`endif
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_ovf;
  logic         busy;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t         vecs[8];
  logic [W+1:0] exp_q[$];   // {cout, ovf, sum}
  logic [W+1:0] mon_e;
  int           n_checks = 0;
  int           n_fail   = 0;

  rca_word_sequencer #(.WORDS(WORDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .cin         (cin),
`ifdef RCA_SEQ_SUB_EN
    .sub         (sub),
`endif
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_sum     (res_sum),
    .res_cout    (res_cout),
    .res_ovf     (res_ovf),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
    logic [W-1:0] be;
    logic [W:0]   t;
    logic         ov;
    be = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (s ? 1'b1 : c)};
    ov = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
    return {t[W], ov, t[W-1:0]};
  endfunction

  // Scoreboard: pop one expectation per completed result handshake.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_sum",  64'(res_sum),  64'(mon_e[W-1:0]));
        check("res_cout", 64'(res_cout), 64'(mon_e[W+1]));
        check("res_ovf",  64'(res_ovf),  64'(mon_e[W]));
      end
    end
  end

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    int k;
    k = 0;
    while (!start_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("start_ready_wait", 64'(start_ready), 64'd1);
    op_a = a;
    op_b = b;
    cin  = c;
`ifdef RCA_SEQ_SUB_EN
    sub  = s;
`else
    if (s) $display("note: sub request ignored in add-only build");
`endif
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    // Operands must be ignored after the accept edge.
    op_a = $urandom;
    op_b = $urandom;
    cin  = 1'($urandom_range(0, 1));
`ifdef RCA_SEQ_SUB_EN
    sub  = 1'($urandom_range(0, 1));
`endif
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, input logic [W+1:0] e, input int hold);
    int lat;
    res_ready = (hold == 0);
    exp_q.push_back(e);
    accept(a, b, c, s);
    check("busy_after_accept", 64'(busy), 64'd1);
    lat = 0;
    while (!res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(LAT));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_valid",       64'(res_valid),   64'd1);
        check("hold_sum",         64'(res_sum),     64'(e[W-1:0]));
        check("hold_start_ready", 64'(start_ready), 64'd0);
        start_valid = 1'b1;
      end
      start_valid = 1'b0;
      res_ready   = 1'b1;
      @(posedge clk); #1;
      check("ack_valid_low", 64'(res_valid), 64'd0);
      check("ack_idle",      64'(start_ready), 64'd1);
      check("ack_not_busy",  64'(busy), 64'd0);
    end else begin
      @(posedge clk); #1;
      check("pulse_valid_low", 64'(res_valid), 64'd0);
    end
  endtask

  initial begin
    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[5] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[7] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};

    rst         = 1'b1;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    op_a        = '0;
    op_b        = '0;
    cin         = 1'b0;
`ifdef RCA_SEQ_SUB_EN
    sub         = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ready", 64'(start_ready), 64'd1);
    check("rst_res_valid",   64'(res_valid),   64'd0);
    check("rst_busy",        64'(busy),        64'd0);
    check("rst_res_sum",     64'(res_sum),     64'd0);
    check("rst_res_cout",    64'(res_cout),    64'd0);
    check("rst_res_ovf",     64'(res_ovf),     64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, {vecs[i].co, vecs[i].ov, vecs[i].s}, 0);

    // Result held in DONE for 5 cycles with competing start requests.
    run_op(32'h0A0B0C0D, 32'h01010101, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0B0C0D0E}, 5);

    // Reset while waiting on byte 2: request discarded, outputs cleared at once.
    res_ready = 1'b0;
    accept(32'h11111111, 32'h22222222, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(res_valid),   64'd0);
    check("mid_rst_sum",   64'(res_sum),     64'd0);
    check("mid_rst_ready", 64'(start_ready), 64'd1);
    check("mid_rst_busy",  64'(busy),        64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(32'h12345678, 32'h11111111, 1'b1, 1'b0, {1'b0, 1'b0, 32'h2345678A}, 0);

`ifdef RCA_SEQ_SUB_EN
    run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFFFFFE}, 0);
    run_op(32'h00000007, 32'h00000005, 1'b0, 1'b1, {1'b1, 1'b0, 32'h00000002}, 1);
    run_op(32'h80000000, 32'h00000001, 1'b1, 1'b1, {1'b1, 1'b1, 32'h7FFFFFFF}, 0);
`endif

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rs;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
`ifdef RCA_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs), int'($urandom_range(0, 2)));
    end

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
